// File: rtl/cadder_pipe.sv
// -----------------------------------------------------------------------------
// cadder_pipe
//   Pipelined WIDTH-bit adder split into SEGMENTS carry segments of
//   SW = WIDTH/SEGMENTS bits each, behind a valid/ready handshake. Stage k adds
//   operand bits [k*SW +: SW] plus the carry registered by stage k-1. The whole
//   pipe advances together (no skid buffering), so backpressure freezes every
//   stage. CARRY_ERROR=1 drops the carry leaving segment ERR_SEG so golden
//   tests can see a defect at a known bit position. A saturating counter
//   tallies delivered results whose final carry is set.
//
// Ports
//   clk        in   clock, all state on the rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand pair offered
//   in_ready   out  operands accepted this cycle (pipe is advancing)
//   A, B       in   WIDTH-bit operands
//   out_valid  out  Z holds a result
//   out_ready  in   downstream takes Z
//   Z          out  WIDTH+1-bit sum, bit WIDTH is the final carry
//   carry_cnt  out  saturating count of delivered results with Z[WIDTH]=1
//   cnt_clr    in   synchronous clear of carry_cnt (wins over an increment)
// -----------------------------------------------------------------------------
module cadder_pipe #(
  parameter int WIDTH       = 4,
  parameter int SEGMENTS    = 2,
  parameter int CARRY_ERROR = 0,
  parameter int ERR_SEG     = 0,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   Z,
  output logic [CNT_W-1:0] carry_cnt,
  input  logic             cnt_clr
);

  localparam int SW = WIDTH / SEGMENTS;

  genvar gi;

  generate
    if ((WIDTH % SEGMENTS) != 0) begin : g_bad_split
      $error("cadder_pipe: WIDTH must be divisible by SEGMENTS");
    end
    if ((CARRY_ERROR != 0) && (SEGMENTS > 1) &&
        ((ERR_SEG < 0) || (ERR_SEG > SEGMENTS - 2))) begin : g_bad_err_seg
      $error("cadder_pipe: ERR_SEG must lie in 0..SEGMENTS-2");
    end
  endgenerate

  logic             out_valid_q;
  logic [WIDTH:0]   z_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             advance;
  logic             last_v;
  logic [WIDTH:0]   z_d;

  // Pipe moves whenever the output slot is empty or being drained.
  assign advance = ~out_valid_q | out_ready;

  // Intermediate stages 0..SEGMENTS-2. Stage gi holds the low (gi+1)*SW sum
  // bits, its carry-out and the operand bits not yet consumed.
  generate
    for (gi = 0; gi < SEGMENTS - 1; gi++) begin : g_stg
      localparam int   LO   = (gi + 1) * SW;
      localparam int   REM  = WIDTH - LO;
      localparam logic KILL = (CARRY_ERROR != 0) && (gi == ERR_SEG);

      logic            valid_q;
      logic [LO-1:0]   sum_q;
      logic            carry_q;
      logic [REM-1:0]  a_q;
      logic [REM-1:0]  b_q;

      logic            v_in;
      logic            c_in;
      logic [SW-1:0]   a_seg;
      logic [SW-1:0]   b_seg;
      logic [REM-1:0]  a_hi;
      logic [REM-1:0]  b_hi;
      logic [SW:0]     seg_sum;
      logic [LO-1:0]   sum_d;

      if (gi == 0) begin : g_src
        assign v_in  = in_valid;
        assign c_in  = 1'b0;
        assign a_seg = A[SW-1:0];
        assign b_seg = B[SW-1:0];
        assign a_hi  = A[WIDTH-1:SW];
        assign b_hi  = B[WIDTH-1:SW];
        assign sum_d = seg_sum[SW-1:0];
      end else begin : g_src
        assign v_in  = g_stg[gi-1].valid_q;
        assign c_in  = g_stg[gi-1].carry_q;
        assign a_seg = g_stg[gi-1].a_q[SW-1:0];
        assign b_seg = g_stg[gi-1].b_q[SW-1:0];
        assign a_hi  = g_stg[gi-1].a_q[REM+SW-1:SW];
        assign b_hi  = g_stg[gi-1].b_q[REM+SW-1:SW];
        assign sum_d = {seg_sum[SW-1:0], g_stg[gi-1].sum_q};
      end

      assign seg_sum = {1'b0, a_seg} + {1'b0, b_seg} + {{SW{1'b0}}, c_in};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          sum_q   <= '0;
          carry_q <= 1'b0;
          a_q     <= '0;
          b_q     <= '0;
        end else if (advance) begin
          valid_q <= v_in;
          // Data only loads for real operands so bubbles leave it untouched.
          if (v_in) begin
            sum_q   <= sum_d;
            // The injected defect: this boundary's carry never reaches the
            // next segment.
            carry_q <= seg_sum[SW] & ~KILL;
            a_q     <= a_hi;
            b_q     <= b_hi;
          end
        end
      end
    end

    // Final segment produces the full sum including the final carry.
    if (SEGMENTS == 1) begin : g_last_src
      assign last_v = in_valid;
      assign z_d    = {1'b0, A} + {1'b0, B};
    end else begin : g_last_src
      localparam int P = SEGMENTS - 2;
      logic [SW:0] top_sum;
      assign top_sum = {1'b0, g_stg[P].a_q} + {1'b0, g_stg[P].b_q} +
                       {{SW{1'b0}}, g_stg[P].carry_q};
      assign last_v  = g_stg[P].valid_q;
      assign z_d     = {top_sum, g_stg[P].sum_q};
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_valid_q && out_ready && z_q[WIDTH] && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      z_q         <= '0;
      cnt_q       <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (advance) begin
        out_valid_q <= last_v;
        if (last_v) begin
          z_q <= z_d;
        end
      end
    end
  end

  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign Z         = z_q;
  assign carry_cnt = cnt_q;

endmodule

// File: tb/tb_cadder_pipe.sv
// -----------------------------------------------------------------------------
// tb_cadder_pipe
//   Directed bench for cadder_pipe. Three instances: defaults (u_def),
//   carry error at boundary 0 (u_err) and a 2-bit counter (u_sat). Inputs are
//   driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_cadder_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic       d_in_valid = 1'b0, d_in_ready, d_out_valid, d_out_ready = 1'b0, d_cnt_clr = 1'b0;
  logic [3:0] d_a = '0, d_b = '0;
  logic [4:0] d_z;
  logic [7:0] d_cnt;
  // carry-error instance
  logic       e_in_valid = 1'b0, e_in_ready, e_out_valid, e_out_ready = 1'b0, e_cnt_clr = 1'b0;
  logic [3:0] e_a = '0, e_b = '0;
  logic [4:0] e_z;
  logic [7:0] e_cnt;
  // saturation instance
  logic       s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b0, s_cnt_clr = 1'b0;
  logic [3:0] s_a = '0, s_b = '0;
  logic [4:0] s_z;
  logic [1:0] s_cnt;

  cadder_pipe u_def (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .A(d_a), .B(d_b), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .Z(d_z), .carry_cnt(d_cnt), .cnt_clr(d_cnt_clr)
  );

  cadder_pipe #(.CARRY_ERROR(1), .ERR_SEG(0)) u_err (
    .clk(clk), .rst_n(rst_n), .in_valid(e_in_valid), .in_ready(e_in_ready),
    .A(e_a), .B(e_b), .out_valid(e_out_valid), .out_ready(e_out_ready),
    .Z(e_z), .carry_cnt(e_cnt), .cnt_clr(e_cnt_clr)
  );

  cadder_pipe #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .A(s_a), .B(s_b), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .Z(s_z), .carry_cnt(s_cnt), .cnt_clr(s_cnt_clr)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] bp_a [3];
  logic [3:0] bp_b [3];
  logic [4:0] err_z [3];

  initial begin
    // ---------------- reset state ----------------
    repeat (2) tick;
    check("rst_out_valid", {31'd0, d_out_valid}, 0);
    check("rst_z", {27'd0, d_z}, 0);
    check("rst_cnt", {24'd0, d_cnt}, 0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, d_in_ready}, 1);

    // ---------------- single op 7+9 ----------------
    d_out_ready = 1'b1;
    d_a = 4'd7; d_b = 4'd9; d_in_valid = 1'b1;
    tick;                           // accepted at this edge
    d_in_valid = 1'b0;
    check("lat_c1_valid", {31'd0, d_out_valid}, 0);
    tick;
    check("lat_c2_valid", {31'd0, d_out_valid}, 1);
    check("lat_c2_z", {27'd0, d_z}, 16);
    tick;                           // handshake done
    check("lat_cnt", {24'd0, d_cnt}, 1);
    check("lat_c3_valid", {31'd0, d_out_valid}, 0);

    // ---------------- streaming 1..15 + 1 ----------------
    d_cnt_clr = 1'b1;
    tick;
    d_cnt_clr = 1'b0;
    check("clr_cnt", {24'd0, d_cnt}, 0);
    for (int c = 0; c <= 16; c++) begin
      d_in_valid = (c < 15);
      d_a = 4'(c + 1);
      d_b = 4'd1;
      tick;
      // op accepted at c shows up at c+1 with Z = (c+1)+1
      if (c >= 1 && c <= 15)
        check($sformatf("stream_%0d", c), {26'd0, d_out_valid, d_z}, {26'd0, 1'b1, 5'(c + 1)});
    end
    d_in_valid = 1'b0;
    check("stream_end_valid", {31'd0, d_out_valid}, 0);
    check("stream_cnt", {24'd0, d_cnt}, 1);

    // ---------------- carry error, boundary 0 ----------------
    e_out_ready = 1'b1;
    e_a = 4'd3;  e_b = 4'd1;  err_z[0] = 5'd0;
    e_in_valid = 1'b1;
    tick;
    e_a = 4'd15; e_b = 4'd15; err_z[1] = 5'd26;
    tick;
    check("err_0", {26'd0, e_out_valid, e_z}, {26'd0, 1'b1, err_z[0]});
    e_a = 4'd4;  e_b = 4'd8;  err_z[2] = 5'd12;
    tick;
    check("err_1", {26'd0, e_out_valid, e_z}, {26'd0, 1'b1, err_z[1]});
    e_in_valid = 1'b0;
    tick;
    check("err_2", {26'd0, e_out_valid, e_z}, {26'd0, 1'b1, err_z[2]});
    tick;
    check("err_end_valid", {31'd0, e_out_valid}, 0);

    // ---------------- backpressure ----------------
    bp_a[0] = 4'd2;  bp_b[0] = 4'd3;   // 5
    bp_a[1] = 4'd10; bp_b[1] = 4'd6;   // 16
    bp_a[2] = 4'd9;  bp_b[2] = 4'd9;   // 18
    d_out_ready = 1'b0;
    d_in_valid = 1'b1;
    d_a = bp_a[0]; d_b = bp_b[0];
    tick;
    d_a = bp_a[1]; d_b = bp_b[1];
    tick;
    d_a = bp_a[2]; d_b = bp_b[2];   // held offered until the pipe moves
    check("bp_in_ready_0", {31'd0, d_in_ready}, 0);
    for (int s = 0; s < 5; s++) begin
      tick;
      check($sformatf("bp_stall_%0d", s), {25'd0, d_in_ready, d_out_valid, d_z}, {25'd0, 1'b0, 1'b1, 5'd5});
    end
    d_out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, d_in_ready}, 1);
    tick;                           // delivers 5, accepts third op
    d_in_valid = 1'b0;
    check("bp_out_1", {26'd0, d_out_valid, d_z}, {26'd0, 1'b1, 5'd16});
    tick;
    check("bp_out_2", {26'd0, d_out_valid, d_z}, {26'd0, 1'b1, 5'd18});
    tick;
    check("bp_drained", {31'd0, d_out_valid}, 0);
    check("bp_cnt", {24'd0, d_cnt}, 3);

    // ---------------- reset mid-flight ----------------
    d_a = 4'd15; d_b = 4'd15; d_in_valid = 1'b1;
    tick;
    d_in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_valid", {31'd0, d_out_valid}, 0);
    check("mrst_z", {27'd0, d_z}, 0);
    check("mrst_cnt", {24'd0, d_cnt}, 0);
    tick;
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick;
      check($sformatf("mrst_idle_%0d", s), {26'd0, d_out_valid, d_z}, 0);
    end
    d_a = 4'd5; d_b = 4'd6; d_in_valid = 1'b1;
    tick;
    d_in_valid = 1'b0;
    check("mrst_lat1", {31'd0, d_out_valid}, 0);
    tick;
    check("mrst_lat2", {26'd0, d_out_valid, d_z}, {26'd0, 1'b1, 5'd11});
    tick;

    // ---------------- counter saturation / clear ----------------
    s_out_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      s_in_valid = (t < 5);
      s_a = 4'd12; s_b = 4'd4;      // 16, carry set
      tick;
    end
    s_in_valid = 1'b0;
    check("sat_cnt", {30'd0, s_cnt}, 3);
    s_a = 4'd8; s_b = 4'd8; s_in_valid = 1'b1;
    tick;
    s_in_valid = 1'b0;
    tick;
    check("sat_pre_clr_valid", {26'd0, s_out_valid, s_z}, {26'd0, 1'b1, 5'd16});
    s_cnt_clr = 1'b1;               // coincides with a carrying handshake
    tick;
    s_cnt_clr = 1'b0;
    check("sat_clr_cnt", {30'd0, s_cnt}, 0);
    tick;
    check("sat_after_clr", {30'd0, s_cnt}, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
